// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode hazard/forwarding unit.
// Tag entries use fixed maximum field widths so the struct can live here.
package hazard_pkg;

  localparam int FWD_RF   = 0;
  localparam int ADDR_MAX = 8;
  localparam int IDX_W    = 4;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [ADDR_MAX-1:0] addr;
    logic [IDX_W-1:0]    ready_idx;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int fwd_stage(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/hazard_fwd_src.sv
// Per-source youngest-match search over the in-flight tags.
// Produces forwarded data, select code and a not-yet-ready hazard flag.
module hazard_fwd_src
  import hazard_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int NSTAGE = 3,
  parameter int FS_W   = 2
) (
  input  tag_t [NSTAGE-1:0]     tags,
  input  logic [RA_W-1:0]       src,
  input  logic [XLEN-1:0]       rf,
  input  logic [NSTAGE*XLEN-1:0] stage_data,
  output logic [XLEN-1:0]       data,
  output logic [FS_W-1:0]       fwd_sel,
  output logic                  hazard
);

  // Oldest first, so the youngest match overrides everything older.
  always_comb begin
    data    = rf;
    fwd_sel = FS_W'(FWD_RF);
    hazard  = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (tags[i].valid && tags[i].we &&
          tags[i].addr == ADDR_MAX'(src) &&
          src != '0) begin
        if (IDX_W'(i) >= tags[i].ready_idx) begin
          data    = stage_data[i*XLEN +: XLEN];
          fwd_sel = FS_W'(fwd_stage(i));
          hazard  = 1'b0;
        end else begin
          data    = rf;
          fwd_sel = FS_W'(FWD_RF);
          hazard  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dec_hazard_scoreboard.sv
// Decode-stage hazard, forwarding and stall unit.
// Holds the tag shift register, the MDU busy counter and the stall logic.
module dec_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int NSRC     = 2,
  parameter int NSTAGE   = 3,
  parameter int LD_READY = 1,
  parameter int MDU_LAT  = 4,
  localparam int FS_W    = clog2(NSTAGE + 1),
  localparam int CNT_W   = clog2(MDU_LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   dec_valid,
  input  logic [NSRC*RA_W-1:0]   dec_src_addr,
  input  logic [NSRC*XLEN-1:0]   dec_src_rf,
  input  logic [RA_W-1:0]        dec_dst_addr,
  input  logic                   dec_we,
  input  logic                   dec_is_load,
  input  logic                   dec_is_mdu,
  input  logic                   flush,
  input  logic [NSTAGE*XLEN-1:0] stage_data,
  output logic [NSRC*XLEN-1:0]   src_data,
  output logic [NSRC*FS_W-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   mdu_busy
);

  tag_t [NSTAGE-1:0] tag_q;
  tag_t              dec_tag;
  logic [NSRC-1:0]   src_haz;
  logic [CNT_W-1:0]  mdu_cnt;
  logic              issue;

  always_comb begin
    dec_tag           = '0;
    dec_tag.valid     = 1'b1;
    dec_tag.we        = dec_we;
    dec_tag.addr      = ADDR_MAX'(dec_dst_addr);
    dec_tag.ready_idx = dec_is_load ? IDX_W'(LD_READY) : '0;
  end

  assign stall = dec_valid && !flush &&
                 ((|src_haz) || (dec_is_mdu && mdu_busy));
  assign issue = dec_valid && !stall && !flush;
  assign mdu_busy = |mdu_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= issue ? dec_tag : '0;
      for (int i = 1; i < NSTAGE; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  // An issued MDU op is never cancelled, so the count ignores stall/flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      mdu_cnt <= '0;
    else if (issue && dec_is_mdu)
      mdu_cnt <= CNT_W'(MDU_LAT);
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - CNT_W'(1);
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    hazard_fwd_src #(
      .XLEN   (XLEN),
      .RA_W   (RA_W),
      .NSTAGE (NSTAGE),
      .FS_W   (FS_W)
    ) u_src (
      .tags       (tag_q),
      .src        (dec_src_addr[k*RA_W +: RA_W]),
      .rf         (dec_src_rf[k*XLEN +: XLEN]),
      .stage_data (stage_data),
      .data       (src_data[k*XLEN +: XLEN]),
      .fwd_sel    (fwd_sel[k*FS_W +: FS_W]),
      .hazard     (src_haz[k])
    );
  end

endmodule

// File: tb/tb_dec_hazard_scoreboard.sv
// Directed bench for dec_hazard_scoreboard with a timestamp-based
// reference model of the in-flight instruction history.
module tb_dec_hazard_scoreboard;

  localparam int XLEN = 32, RA_W = 5, NSRC = 2, NSTAGE = 3;
  localparam int LD_READY = 1, MDU_LAT = 4, FS_W = 2;

  logic clk = 1'b0;
  logic rstn;
  logic dec_valid, dec_we, dec_is_load, dec_is_mdu, flush;
  logic [NSRC*RA_W-1:0]   dec_src_addr;
  logic [NSRC*XLEN-1:0]   dec_src_rf;
  logic [RA_W-1:0]        dec_dst_addr;
  logic [NSTAGE*XLEN-1:0] stage_data;
  logic [NSRC*XLEN-1:0]   src_data;
  logic [NSRC*FS_W-1:0]   fwd_sel;
  logic stall, mdu_busy;

  int checks = 0, errors = 0;

  dec_hazard_scoreboard dut (
    .clk          (clk),
    .rstn         (rstn),
    .dec_valid    (dec_valid),
    .dec_src_addr (dec_src_addr),
    .dec_src_rf   (dec_src_rf),
    .dec_dst_addr (dec_dst_addr),
    .dec_we       (dec_we),
    .dec_is_load  (dec_is_load),
    .dec_is_mdu   (dec_is_mdu),
    .flush        (flush),
    .stage_data   (stage_data),
    .src_data     (src_data),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .mdu_busy     (mdu_busy)
  );

  always #5 clk = ~clk;

  // Model: log of what issued in each cycle; an op issued in cycle c
  // sits in stage (now - c - 1). MDU busy for MDU_LAT cycles after issue.
  int cyc = 0, vis = 0, last_mdu = -1000;
  logic       lv  [0:1023];
  logic       lwe [0:1023];
  logic       lld [0:1023];
  logic [4:0] ldst[0:1023];

  function automatic void eval(output logic [NSRC-1:0] hz,
                               output logic [NSRC*FS_W-1:0] fs,
                               output logic [NSRC*XLEN-1:0] dat,
                               output logic st, output logic busy);
    hz = '0; fs = '0; dat = dec_src_rf;
    busy = rstn && (cyc - last_mdu >= 1) && (cyc - last_mdu <= MDU_LAT);
    for (int k = 0; k < NSRC; k++) begin
      logic [4:0] s;
      bit found;
      s = dec_src_addr[k*RA_W +: RA_W];
      found = 0;
      for (int a = 0; a < NSTAGE; a++) begin
        int c;
        c = cyc - 1 - a;
        if (rstn && !found && c >= vis && c >= 0 && s != 0 &&
            lv[c] && lwe[c] && ldst[c] == s) begin
          found = 1;
          if (lld[c] && a < LD_READY) hz[k] = 1'b1;
          else begin
            fs[k*FS_W +: FS_W] = FS_W'(a + 1);
            dat[k*XLEN +: XLEN] = stage_data[a*XLEN +: XLEN];
          end
        end
      end
    end
    st = rstn && dec_valid && !flush && ((|hz) || (dec_is_mdu && busy));
  endfunction

  always @(posedge clk) begin
    logic [NSRC-1:0] hz;
    logic [NSRC*FS_W-1:0] fs;
    logic [NSRC*XLEN-1:0] dat;
    logic st, busy, iss;
    eval(hz, fs, dat, st, busy);
    if (!rstn) begin
      vis = cyc + 1;
      last_mdu = -1000;
      lv[cyc] = 1'b0;
    end else begin
      iss = dec_valid && !st && !flush;
      lv[cyc] = iss;
      lwe[cyc] = dec_we;
      lld[cyc] = dec_is_load;
      ldst[cyc] = dec_dst_addr;
      if (iss && dec_is_mdu) last_mdu = cyc;
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NSRC-1:0] hz;
    logic [NSRC*FS_W-1:0] fs;
    logic [NSRC*XLEN-1:0] dat;
    logic st, busy;
    eval(hz, fs, dat, st, busy);
    chk("model stall", 64'(stall), 64'(st));
    chk("model mdu_busy", 64'(mdu_busy), 64'(busy));
    for (int k = 0; k < NSRC; k++) begin
      if (!hz[k]) begin
        chk("model fwd_sel", 64'(fwd_sel[k*FS_W +: FS_W]),
            64'(fs[k*FS_W +: FS_W]));
        chk("model src_data", 64'(src_data[k*XLEN +: XLEN]),
            64'(dat[k*XLEN +: XLEN]));
      end
    end
  end

  task automatic put(input logic v, input logic [4:0] s0, s1, dst,
                     input logic we, ld, mdu, fl);
    dec_valid = v;
    dec_src_addr = {s1, s0};
    dec_src_rf = {32'hB000_0000 + 32'(s1), 32'hA000_0000 + 32'(s0)};
    dec_dst_addr = dst;
    dec_we = we;
    dec_is_load = ld;
    dec_is_mdu = mdu;
    flush = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      put(0, 0, 0, 0, 0, 0, 0, 0);
      adv();
    end
  endtask

  initial begin
    rstn = 1'b0;
    stage_data = {32'h5555_0003, 32'h0000_DEAD, 32'h0000_1234};
    put(1, 3, 4, 0, 0, 0, 0, 0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset busy", 64'(mdu_busy), 64'd0);
    chk("reset fwd", 64'(fwd_sel), 64'd0);
    chk("reset src1", 64'(src_data[63:32]), 64'hB000_0004);
    adv();
    rstn = 1'b1;
    idle(1);

    // ALU RAW
    put(1, 0, 0, 3, 1, 0, 0, 0);
    adv();
    put(1, 3, 1, 0, 0, 0, 0, 0);
    chk("raw stall", 64'(stall), 64'd0);
    chk("raw fwd", 64'(fwd_sel[1:0]), 64'd1);
    chk("raw data", 64'(src_data[31:0]), 64'h1234);
    adv();
    idle(3);

    // Load-use
    put(1, 0, 0, 5, 1, 1, 0, 0);
    adv();
    put(1, 5, 0, 6, 1, 0, 0, 0);
    chk("ldu stall", 64'(stall), 64'd1);
    adv();
    put(1, 5, 0, 6, 1, 0, 0, 0);
    chk("ldu stall2", 64'(stall), 64'd0);
    chk("ldu fwd", 64'(fwd_sel[1:0]), 64'd2);
    chk("ldu data", 64'(src_data[31:0]), 64'hDEAD);
    adv();
    put(1, 5, 6, 0, 0, 0, 0, 0);
    chk("ldu bubble fwd0", 64'(fwd_sel[1:0]), 64'd3);
    chk("ldu bubble fwd1", 64'(fwd_sel[3:2]), 64'd1);
    adv();
    idle(3);

    // r0 and priority
    put(1, 0, 0, 0, 1, 0, 0, 0);
    adv();
    put(1, 0, 0, 0, 0, 0, 0, 0);
    chk("r0 fwd", 64'(fwd_sel), 64'd0);
    chk("r0 data", 64'(src_data[31:0]), 64'hA000_0000);
    adv();
    put(1, 0, 0, 7, 1, 0, 0, 0);
    adv();
    put(1, 0, 0, 7, 1, 0, 0, 0);
    adv();
    put(1, 7, 7, 0, 0, 0, 0, 0);
    chk("prio fwd", 64'(fwd_sel), 64'h5);
    adv();
    idle(3);

    // Back-to-back MDU
    put(1, 0, 0, 8, 1, 0, 1, 0);
    adv();
    for (int i = 0; i < MDU_LAT; i++) begin
      put(1, 0, 0, 9, 1, 0, 1, 0);
      chk("mdu stall", 64'(stall), 64'd1);
      chk("mdu busy", 64'(mdu_busy), 64'd1);
      adv();
    end
    put(1, 0, 0, 9, 1, 0, 1, 0);
    chk("mdu issue", 64'(stall), 64'd0);
    adv();
    idle(5);

    // Flush during load-use
    put(1, 0, 0, 9, 1, 1, 0, 0);
    adv();
    put(1, 9, 0, 0, 0, 0, 0, 1);
    chk("flush stall", 64'(stall), 64'd0);
    adv();
    put(1, 9, 0, 0, 0, 0, 0, 0);
    chk("post flush stall", 64'(stall), 64'd0);
    chk("post flush fwd", 64'(fwd_sel[1:0]), 64'd2);
    adv();
    idle(3);

    // Reset mid-stall with MDU busy
    put(1, 0, 0, 8, 1, 0, 1, 0);
    adv();
    put(1, 0, 0, 8, 1, 0, 1, 0);
    chk("pre-rst stall", 64'(stall), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst busy", 64'(mdu_busy), 64'd0);
    adv();
    rstn = 1'b1;
    put(1, 8, 3, 0, 0, 0, 0, 0);
    chk("rst rel fwd", 64'(fwd_sel), 64'd0);
    chk("rst rel data", 64'(src_data), {32'hB000_0003, 32'hA000_0008});
    adv();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
